demux_1_4_buf: RTL and testbench
================================

// Module: demux_1_4_buf
// PURPOSE
//   Registered 1-to-4 distributor: the write-side counterpart of the 4:1 output mux.
//   Accepts one 16-bit word per handshake and steers it into one of four single-entry lane buffers.
//   Lane selection is either explicit (select) or automatic round-robin.
//   Feeds the four sub-block operand paths of the block matrix multiplier.
//   Each lane has its own valid/ready handshake.
// PARAMETERS
//   DATA_W  16  width of data word and of each lane buffer
// PORTS
//   clk        in   1       rising-edge clock, single clock domain
//   reset      in   1       synchronous, active-high reset
//   restart    in   1       synchronous; clears round-robin pointer only
//   auto_mode  in   1       1: round-robin lane choice; 0: use select
//   select     in   2       explicit lane index (00->lane1 .. 11->lane4)
//   in_data    in   DATA_W  input word
//   in_valid   in   1       input word present
//   in_ready   out  1       block can accept in_data this cycle
//   out_1..4   out  DATA_W  lane buffer contents, lanes 1..4
//   out_valid  out  4       bit i set: lane i+1 holds unconsumed word
//   out_ready  in   4       bit i set: consumer takes lane i+1 this cycle
//   group_done out  1       1-cycle pulse: 4th word of a round-robin group accepted
//   rr_ptr     out  2       current round-robin lane index
// BEHAVIOUR
// - Reset (reset=1 at clk edge) wins over every other input:
//   - out_1..4=0, out_valid=0, rr_ptr=0, group_done=0.
//   - in_ready is 0 during the reset cycle.
// - target = auto_mode ? rr_ptr : select. Combinational from registered state and inputs.
// - in_ready = !reset && (!out_valid[target] || out_ready[target]).
//   - Combinational.
//   - A full lane being drained the same cycle can be refilled.
// - Accept = in_valid && in_ready. On accept at edge:
//   - out_<target> <= in_data; out_valid[target] <= 1.
// - Drain: out_valid[i] && out_ready[i] with no accept into lane i -> out_valid[i] <= 0.
//   - Drain and accept on the same lane, same cycle: out_valid stays 1 and data is replaced.
// - Data registers hold their last value after drain; they clear only on reset.
// - out_ready on a lane with out_valid=0 is ignored.
// - Independent lanes may drain in the same cycle as an accept into another lane.
// - Latency: word accepted at edge N is visible on out_<lane> with out_valid after edge N.
// - Round-robin pointer:
//   - Increments only on accept with auto_mode=1; wraps 3->0.
//   - group_done <= 1 for exactly one cycle when an accept occurs with rr_ptr=3 and auto_mode=1. Otherwise 0.
// - Round-robin stall:
//   - If lane rr_ptr is full and not draining, in_ready=0 and the pointer holds.
//   - The pointer never skips to a free lane.
// - Manual mode (auto_mode=0): rr_ptr is frozen and retains its value for later auto use.
// - restart=1:
//   - rr_ptr <= 0 and group_done <= 0.
//   - Lane contents and out_valid are unaffected.
//   - A same-cycle accept is still performed into the pre-restart target, but the pointer ends at 0.
// - Reset mid-operation: all buffered words are discarded, with no output pulse.
// - in_data is don't-care when in_valid=0. Nothing is written when in_valid=0.
// TESTING
// - Reset:
//   - Stimulus: reset=1 for 2 cycles with in_valid=1, in_data=16'hFFFF.
//   - Response: out_valid=4'b0000, out_1..4=0, rr_ptr=0, in_ready=0.
// - Manual steer:
//   - Stimulus: auto_mode=0; write select=2 data=16'h1234, then select=0 data=16'h00AB.
//   - Response: out_3=16'h1234, out_1=16'h00AB, out_valid=4'b0101.
// - Round-robin group:
//   - Stimulus: auto_mode=1; out_ready=4'hF; send 5 words 16'd1..5 back to back.
//   - Response: lanes get 1,2,3,4; the 5th word goes to lane1.
//   - Response: group_done high only in the cycle after word 4; rr_ptr=1 at the end.
// - Back-pressure:
//   - Stimulus: auto_mode=1, out_ready=0; send 6 words.
//   - Response: 4 words are accepted; in_ready=0 with rr_ptr=0.
//   - Stimulus: raise out_ready[0].
//   - Response: word 5 is accepted into lane1 the same cycle; out_valid[0] stays 1.
// - Restart:
//   - Stimulus: auto_mode=1; accept 2 words, then pulse restart.
//   - Response: rr_ptr=0, out_valid=4'b0011 unchanged; the next word lands in lane1 once it is drained.
// - Reset mid-stream:
//   - Stimulus: reset with out_valid=4'b1011.
//   - Response: out_valid=0 next cycle; no group_done pulse.

Source files
------------

// File: rtl/demux_1_4_buf_if.sv
// Handshake bundle between the word producer and the four-lane distributor.
// The slave side is the distributor; the master side is whatever feeds it and drains the lanes.
interface demux_1_4_buf_if #(
   parameter int DATA_W = 16
);
   logic              restart;
   logic              auto_mode;
   logic [1:0]        select;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_1;
   logic [DATA_W-1:0] out_2;
   logic [DATA_W-1:0] out_3;
   logic [DATA_W-1:0] out_4;
   logic [3:0]        out_valid;
   logic [3:0]        out_ready;
   logic              group_done;
   logic [1:0]        rr_ptr;

   modport slave (
      input  restart, auto_mode, select, in_data, in_valid, out_ready,
      output in_ready, out_1, out_2, out_3, out_4, out_valid, group_done, rr_ptr
   );

   modport master (
      output restart, auto_mode, select, in_data, in_valid, out_ready,
      input  in_ready, out_1, out_2, out_3, out_4, out_valid, group_done, rr_ptr
   );
endinterface

// File: rtl/demux_1_4_buf.sv
// Registered 1-to-4 distributor: steers each accepted word into one of four
// single-entry lane buffers, chosen explicitly or by a round-robin pointer.
module demux_1_4_buf #(
   parameter int DATA_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   demux_1_4_buf_if.slave  bus
);
   logic [DATA_W-1:0] lane_r [4];
   logic [3:0]        valid_r;
   logic [1:0]        ptr_r;
   logic              done_r;

   logic [1:0]        target_s;
   logic              ready_s;
   logic              accept_s;
   logic [3:0]        wr_s;
   logic [3:0]        valid_nx_s;
   logic [1:0]        ptr_nx_s;
   logic              done_nx_s;

   // Lane choice, handshake and next-state for valid flags, pointer and group pulse
   always_comb begin
      target_s   = 2'd0;
      ready_s    = 1'b0;
      accept_s   = 1'b0;
      wr_s       = 4'b0000;
      valid_nx_s = valid_r;
      ptr_nx_s   = ptr_r;
      done_nx_s  = 1'b0;

      if (bus.auto_mode) begin
         target_s = ptr_r;
      end else begin
         target_s = bus.select;
      end

      // A full lane that is draining this cycle can be refilled immediately.
      if (reset) begin
         ready_s = 1'b0;
      end else begin
         ready_s = !valid_r[target_s] || bus.out_ready[target_s];
      end

      accept_s = bus.in_valid && ready_s;

      if (accept_s) begin
         wr_s = 4'b0001 << target_s;
      end else begin
         wr_s = 4'b0000;
      end

      valid_nx_s = wr_s | (valid_r & ~bus.out_ready);

      // restart still lets the same-cycle accept land, but the pointer ends at 0.
      if (bus.restart) begin
         ptr_nx_s  = 2'd0;
         done_nx_s = 1'b0;
      end else if (accept_s && bus.auto_mode) begin
         ptr_nx_s  = ptr_r + 2'd1;
         done_nx_s = (ptr_r == 2'd3);
      end else begin
         ptr_nx_s  = ptr_r;
         done_nx_s = 1'b0;
      end
   end

   // Lane buffers, valid flags, round-robin pointer and group pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            lane_r[i] <= {DATA_W{1'b0}};
         end
         valid_r <= 4'b0000;
         ptr_r   <= 2'd0;
         done_r  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (wr_s[i]) begin
               lane_r[i] <= bus.in_data;
            end
         end
         valid_r <= valid_nx_s;
         ptr_r   <= ptr_nx_s;
         done_r  <= done_nx_s;
      end
   end

   assign bus.in_ready   = ready_s;
   assign bus.out_1      = lane_r[0];
   assign bus.out_2      = lane_r[1];
   assign bus.out_3      = lane_r[2];
   assign bus.out_4      = lane_r[3];
   assign bus.out_valid  = valid_r;
   assign bus.rr_ptr     = ptr_r;
   assign bus.group_done = done_r;
endmodule

// File: tb/tb_demux_1_4_buf.sv
// Self-checking bench for demux_1_4_buf: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a lane model.
module tb_demux_1_4_buf;
   localparam int DATA_W = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   demux_1_4_buf_if #(.DATA_W(DATA_W)) bus ();
   demux_1_4_buf #(.DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   logic [15:0] m_data  [4];
   bit          m_valid [4];
   int          m_ptr;
   bit          m_done;
   int          done_seen = 0;

   task automatic expect_eq(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] dut_lane(int i);
      case (i)
         0:       return bus.out_1;
         1:       return bus.out_2;
         2:       return bus.out_3;
         default: return bus.out_4;
      endcase
   endfunction

   function automatic logic [3:0] m_valid_vec();
      return {m_valid[3], m_valid[2], m_valid[1], m_valid[0]};
   endfunction

   function automatic int m_target();
      return bus.auto_mode ? m_ptr : int'(bus.select);
   endfunction

   function automatic bit m_ready();
      int t;
      if (reset) return 1'b0;
      t = m_target();
      return !m_valid[t] || bus.out_ready[t];
   endfunction

   // One clock edge of the behavioural model, from the inputs present before the edge
   task automatic model_step();
      int t;
      bit acc;
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            m_data[i]  = 16'h0000;
            m_valid[i] = 1'b0;
         end
         m_ptr  = 0;
         m_done = 1'b0;
      end else begin
         t   = m_target();
         acc = bus.in_valid && m_ready();
         for (int i = 0; i < 4; i++) begin
            if (acc && i == t) begin
               m_data[i]  = bus.in_data;
               m_valid[i] = 1'b1;
            end else if (bus.out_ready[i]) begin
               m_valid[i] = 1'b0;
            end
         end
         m_done = !bus.restart && acc && bus.auto_mode && m_ptr == 3;
         if (bus.restart) m_ptr = 0;
         else if (acc && bus.auto_mode) m_ptr = (m_ptr + 1) % 4;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 4; i++) begin
            expect_eq($sformatf("out_%0d", i + 1), dut_lane(i), m_data[i]);
         end
         expect_eq("out_valid", bus.out_valid, m_valid_vec());
         expect_eq("rr_ptr", bus.rr_ptr, m_ptr[1:0]);
         expect_eq("group_done", bus.group_done, m_done);
         expect_eq("in_ready", bus.in_ready, m_ready());
         if (bus.group_done) done_seen++;
      end
   end

   initial begin
      reset         = 1'b1;
      bus.restart   = 1'b0;
      bus.auto_mode = 1'b0;
      bus.select    = 2'd0;
      bus.in_data   = 16'hFFFF;
      bus.in_valid  = 1'b1;
      bus.out_ready = 4'b0000;

      // Reset held two cycles with a word offered
      tick();
      chk_en = 1'b1;
      tick();
      expect_eq("rst_out_valid", bus.out_valid, 4'b0000);
      expect_eq("rst_out_1", bus.out_1, 16'h0000);
      expect_eq("rst_out_4", bus.out_4, 16'h0000);
      expect_eq("rst_rr_ptr", bus.rr_ptr, 2'd0);
      expect_eq("rst_in_ready", bus.in_ready, 1'b0);
      reset = 1'b0;

      // Manual steering
      bus.select = 2'd2; bus.in_data = 16'h1234; tick();
      bus.select = 2'd0; bus.in_data = 16'h00AB; tick();
      bus.in_valid = 1'b0;
      expect_eq("man_out_3", bus.out_3, 16'h1234);
      expect_eq("man_out_1", bus.out_1, 16'h00AB);
      expect_eq("man_out_valid", bus.out_valid, 4'b0101);
      expect_eq("man_rr_ptr", bus.rr_ptr, 2'd0);
      bus.out_ready = 4'b1111; tick();

      // Round-robin group of five words
      bus.auto_mode = 1'b1; bus.in_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         bus.in_data = 16'(k);
         tick();
         if (k == 2) expect_eq("rr_out_2", bus.out_2, 16'd2);
         if (k == 3) expect_eq("rr_done_early", bus.group_done, 1'b0);
         if (k == 4) begin
            expect_eq("rr_done_pulse", bus.group_done, 1'b1);
            expect_eq("rr_out_4", bus.out_4, 16'd4);
         end
      end
      expect_eq("rr_out_1_wrap", bus.out_1, 16'd5);
      expect_eq("rr_done_clear", bus.group_done, 1'b0);
      expect_eq("rr_ptr_end", bus.rr_ptr, 2'd1);
      bus.in_valid = 1'b0; tick();
      bus.restart = 1'b1; tick();
      bus.restart = 1'b0;

      // Back-pressure: only four words fit
      bus.out_ready = 4'b0000; bus.in_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         bus.in_data = 16'h0010 + 16'(k);
         tick();
      end
      expect_eq("bp_out_valid", bus.out_valid, 4'b1111);
      expect_eq("bp_rr_ptr", bus.rr_ptr, 2'd0);
      expect_eq("bp_in_ready", bus.in_ready, 1'b0);
      expect_eq("bp_out_1", bus.out_1, 16'h0011);
      bus.out_ready = 4'b0001; bus.in_data = 16'h0055;
      #1;
      expect_eq("bp_refill_ready", bus.in_ready, 1'b1);
      tick();
      expect_eq("bp_refill_out_1", bus.out_1, 16'h0055);
      expect_eq("bp_refill_valid", bus.out_valid, 4'b1111);
      expect_eq("bp_refill_ptr", bus.rr_ptr, 2'd1);

      // Restart keeps lane contents
      bus.in_valid = 1'b0; bus.out_ready = 4'b1111; tick();
      bus.out_ready = 4'b0000; bus.restart = 1'b1; tick();
      bus.restart = 1'b0; bus.in_valid = 1'b1;
      bus.in_data = 16'h00A1; tick();
      bus.in_data = 16'h00A2; tick();
      bus.in_valid = 1'b0; bus.restart = 1'b1; tick();
      bus.restart = 1'b0;
      expect_eq("rs_rr_ptr", bus.rr_ptr, 2'd0);
      expect_eq("rs_out_valid", bus.out_valid, 4'b0011);
      bus.in_valid = 1'b1; bus.in_data = 16'h0077; tick();
      expect_eq("rs_blocked_out_1", bus.out_1, 16'h00A1);
      bus.out_ready = 4'b0001; tick();
      expect_eq("rs_out_1", bus.out_1, 16'h0077);
      expect_eq("rs_out_valid2", bus.out_valid, 4'b0011);
      bus.in_valid = 1'b0; bus.out_ready = 4'b0000;

      // Reset mid-stream with lanes 1, 2 and 4 occupied
      bus.auto_mode = 1'b0; bus.select = 2'd3; bus.in_valid = 1'b1; bus.in_data = 16'hBEEF;
      tick();
      bus.in_valid = 1'b0;
      expect_eq("mid_out_valid", bus.out_valid, 4'b1011);
      reset = 1'b1; tick();
      reset = 1'b0;
      expect_eq("mid_rst_valid", bus.out_valid, 4'b0000);
      expect_eq("mid_rst_done", bus.group_done, 1'b0);
      expect_eq("mid_rst_out_4", bus.out_4, 16'h0000);

      // Randomized traffic
      bus.auto_mode = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         reset         = ($urandom_range(0, 99) == 0);
         bus.restart   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 31) == 0) bus.auto_mode = ~bus.auto_mode;
         bus.select    = 2'($urandom_range(0, 3));
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = 16'($urandom);
         bus.out_ready = 4'($urandom_range(0, 15));
         tick();
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (done_seen == 0) begin
         failures++;
         $display("FAIL group_done_seen actual=%0d expected=nonzero", done_seen);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
